spi_follower: RTL and testbench

SPI_FOLLOWER -- requirements
Module: spi_follower

---
 rtl/spi_follower.sv | 194 +++++++++++++++++++
 tb/tb_spi_follower.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_follower.sv
// SPI follower: synchronises the leader's ext_clk/cs/in into clk, supports all
// four cpol/cpha modes with 8- or 16-bit frames and back-to-back frames under one cs low.
//   state  | meaning
//   IDLE   | cs high; out held at 0, waiting for a cs fall
//   ACTIVE | cs low; shifting frames, busy high
module spi_follower (
  input  logic        clk,
  input  logic        rst,
  input  logic        ext_clk,
  input  logic        cs,
  input  logic        in,
  output logic        out,
  input  logic        cpol,
  input  logic        cpha,
  input  logic        len,
  input  logic [15:0] tx_data,
  input  logic        tx_load,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic        busy
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cs_sync_q, cs_sync_d;
  logic [1:0]  sck_sync_q, sck_sync_d;
  logic [1:0]  mosi_sync_q, mosi_sync_d;
  logic        cs_prev_q, cs_prev_d;
  logic        sck_prev_q, sck_prev_d;
  logic [1:0]  settle_q, settle_d;
  logic        armed_q, armed_d;
  logic        cpol_q, cpol_d;
  logic        cpha_q, cpha_d;
  logic        len_q, len_d;
  logic [15:0] tx_buf_q, tx_buf_d;
  logic [15:0] tx_sr_q, tx_sr_d;
  logic [15:0] rx_sr_q, rx_sr_d;
  logic [4:0]  count_q, count_d;
  logic        skip_q, skip_d;
  logic [15:0] rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        out_q, out_d;
  logic        busy_q, busy_d;

  logic        cs_s, sck_s, mosi_s;
  logic        cs_fall, cs_rise, sck_rise, sck_fall;
  logic        lead_edge, trail_edge, sample_stb, shift_stb;
  logic [4:0]  count_inc, frame_len;
  logic [15:0] rx_shift;

  assign cs_s       = cs_sync_q[1];
  assign sck_s      = sck_sync_q[1];
  assign mosi_s     = mosi_sync_q[1];
  assign cs_fall    = cs_prev_q & ~cs_s;
  assign cs_rise    = ~cs_prev_q & cs_s;
  assign sck_rise   = sck_s & ~sck_prev_q;
  assign sck_fall   = ~sck_s & sck_prev_q;
  assign lead_edge  = cpol_q ? sck_fall : sck_rise;
  assign trail_edge = cpol_q ? sck_rise : sck_fall;
  assign sample_stb = cpha_q ? trail_edge : lead_edge;
  assign shift_stb  = cpha_q ? lead_edge : trail_edge;
  assign count_inc  = count_q + 5'd1;
  assign frame_len  = len_q ? 5'd16 : 5'd8;
  assign rx_shift   = {rx_sr_q[14:0], mosi_s};

  always_comb begin
    state_d     = state_q;
    cs_sync_d   = {cs_sync_q[0], cs};
    sck_sync_d  = {sck_sync_q[0], ext_clk};
    mosi_sync_d = {mosi_sync_q[0], in};
    cs_prev_d   = cs_s;
    sck_prev_d  = sck_s;
    settle_d    = {settle_q[0], 1'b1};
    armed_d     = armed_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    len_d       = len_q;
    tx_buf_d    = tx_load ? tx_data : tx_buf_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    count_d     = count_q;
    skip_d      = skip_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    // After reset, only a cs fall seen after a genuinely high cs starts a frame.
    if (settle_q[1] && cs_s) begin
      armed_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (armed_q && cs_fall) begin
          state_d = ACTIVE;
          cpol_d  = cpol;
          cpha_d  = cpha;
          len_d   = len;
          tx_sr_d = tx_buf_q;
          rx_sr_d = 16'h0000;
          count_d = 5'd0;
          skip_d  = cpha;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d     = IDLE;
          count_d     = 5'd0;
          frame_err_d = (count_q != 5'd0);
        end else if (sample_stb) begin
          rx_sr_d = rx_shift;
          if (count_inc == frame_len) begin
            rx_data_d  = len_q ? rx_shift : {8'h00, rx_shift[7:0]};
            rx_valid_d = 1'b1;
            count_d    = 5'd0;
            tx_sr_d    = tx_buf_q;
            skip_d     = 1'b1;
          end else begin
            count_d = count_inc;
          end
        end else if (shift_stb) begin
          // The first shift edge of a cpha=1 frame and the one after a frame's last sample are dropped.
          if (skip_q) begin
            skip_d = 1'b0;
          end else begin
            tx_sr_d = {tx_sr_q[14:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == ACTIVE);
    out_d  = (state_d == ACTIVE) && (len_d ? tx_sr_d[15] : tx_sr_d[7]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cs_sync_q   <= 2'b11;
      sck_sync_q  <= 2'b00;
      mosi_sync_q <= 2'b00;
      cs_prev_q   <= 1'b1;
      sck_prev_q  <= 1'b0;
      settle_q    <= 2'b00;
      armed_q     <= 1'b0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      len_q       <= 1'b0;
      tx_buf_q    <= 16'h0000;
      tx_sr_q     <= 16'h0000;
      rx_sr_q     <= 16'h0000;
      count_q     <= 5'd0;
      skip_q      <= 1'b0;
      rx_data_q   <= 16'h0000;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      out_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_sync_q   <= cs_sync_d;
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_prev_q   <= cs_prev_d;
      sck_prev_q  <= sck_prev_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      len_q       <= len_d;
      tx_buf_q    <= tx_buf_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      count_q     <= count_d;
      skip_q      <= skip_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      out_q       <= out_d;
      busy_q      <= busy_d;
    end
  end

  assign out       = out_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spi_follower.sv
// Bench for spi_follower: a behavioural SPI leader drives frames in all modes and
// results are compared against word-level expectations (tx word out, rx word in).
`timescale 1ns/1ps
module tb_spi_follower;

  localparam int HALF = 60;

  logic        clk = 1'b0;
  logic        rst;
  logic        ext_clk;
  logic        cs;
  logic        mosi;
  logic        out;
  logic        cpol, cpha, len;
  logic [15:0] tx_data;
  logic        tx_load;
  logic [15:0] rx_data;
  logic        rx_valid, frame_err, busy;

  spi_follower dut (
    .clk(clk), .rst(rst), .ext_clk(ext_clk), .cs(cs), .in(mosi), .out(out),
    .cpol(cpol), .cpha(cpha), .len(len), .tx_data(tx_data), .tx_load(tx_load),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Event monitor, sampled on the inactive edge.
  logic [15:0] rxq[$];
  int n_valid = 0, n_err = 0, n_both = 0, n_out_idle = 0;
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rxq.push_back(rx_data);
      n_valid++;
    end
    if (frame_err === 1'b1) n_err++;
    if (rx_valid === 1'b1 && frame_err === 1'b1) n_both++;
    if (busy === 1'b0 && out === 1'b1) n_out_idle++;
  end

  bit          m_cpol, m_cpha;
  logic [15:0] miso_acc;
  logic [15:0] model_rx;

  // Leader: sends bits [first .. first+nbits-1] of an fbits-wide word, MSB first.
  task automatic leader_bits(input logic [15:0] word, input int first, input int nbits, input int fbits);
    for (int i = first; i < first + nbits; i++) begin
      if (!m_cpha) begin
        mosi = word[fbits-1-i];
        #HALF;
        miso_acc = {miso_acc[14:0], out};
        ext_clk = ~m_cpol;
        #HALF;
        ext_clk = m_cpol;
      end else begin
        #HALF;
        ext_clk = ~m_cpol;
        mosi = word[fbits-1-i];
        #HALF;
        miso_acc = {miso_acc[14:0], out};
        ext_clk = m_cpol;
      end
    end
  endtask

  task automatic set_mode(input bit c_pol, input bit c_pha, input bit l);
    cpol = c_pol; cpha = c_pha; len = l;
    m_cpol = c_pol; m_cpha = c_pha;
    ext_clk = c_pol;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_load(input logic [15:0] d);
    @(negedge clk);
    tx_data = d;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic end_frame();
    #HALF;
    cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic run_frame(input bit c_pol, input bit c_pha, input bit l, input logic [15:0] tx,
                           input logic [15:0] rxw, input string tag, input bit scramble);
    int v0, e0, fb;
    logic [15:0] exp_tx;
    v0 = n_valid;
    e0 = n_err;
    fb = l ? 16 : 8;
    exp_tx = l ? tx : {8'h00, tx[7:0]};
    model_rx = l ? rxw : {8'h00, rxw[7:0]};
    set_mode(c_pol, c_pha, l);
    pulse_load(tx);
    @(negedge clk);
    cs = 1'b0;
    miso_acc = 16'h0000;
    leader_bits(rxw, 0, 1, fb);
    if (scramble) begin
      cpol = 1'($urandom_range(0, 1));
      cpha = 1'($urandom_range(0, 1));
      len  = 1'($urandom_range(0, 1));
    end
    leader_bits(rxw, 1, fb - 1, fb);
    end_frame();
    check({tag, " miso"}, miso_acc, exp_tx);
    check({tag, " valid_cnt"}, n_valid - v0, 1);
    check({tag, " rx_last"}, (rxq.size() > 0) ? rxq[rxq.size()-1] : 16'hxxxx, model_rx);
    check({tag, " rx_data"}, rx_data, model_rx);
    check({tag, " err_cnt"}, n_err - e0, 0);
    check({tag, " busy_end"}, busy, 1'b0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int v0, e0;
    logic [15:0] m1;
    rst = 1'b1; cs = 1'b1; ext_clk = 1'b0; mosi = 1'b0;
    cpol = 1'b0; cpha = 1'b0; len = 1'b0; tx_data = 16'h0000; tx_load = 1'b0;
    model_rx = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst rx_data", rx_data, 16'h0000);
    check("rst rx_valid", rx_valid, 1'b0);
    check("rst frame_err", frame_err, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst out", out, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    run_frame(1'b0, 1'b0, 1'b0, 16'h00A5, 16'h003C, "mode0", 1'b0);
    run_frame(1'b1, 1'b1, 1'b1, 16'hBEEF, 16'h1234, "mode3", 1'b0);

    // Two 8-bit frames under one cs low; new tx word loaded during the first.
    v0 = n_valid; e0 = n_err;
    set_mode(1'b0, 1'b0, 1'b0);
    pulse_load(16'h00C3);
    @(negedge clk);
    cs = 1'b0;
    miso_acc = 16'h0000;
    leader_bits(16'h0001, 0, 4, 8);
    pulse_load(16'h005A);
    leader_bits(16'h0001, 4, 4, 8);
    m1 = miso_acc;
    miso_acc = 16'h0000;
    leader_bits(16'h0002, 0, 8, 8);
    end_frame();
    model_rx = 16'h0002;
    check("b2b miso1", m1, 16'h00C3);
    check("b2b miso2", miso_acc, 16'h005A);
    check("b2b valid_cnt", n_valid - v0, 2);
    check("b2b rx_first", (rxq.size() > 1) ? rxq[rxq.size()-2] : 16'hxxxx, 16'h0001);
    check("b2b rx_second", (rxq.size() > 0) ? rxq[rxq.size()-1] : 16'hxxxx, 16'h0002);
    check("b2b err_cnt", n_err - e0, 0);

    // cs raised after 5 of 8 bits.
    v0 = n_valid; e0 = n_err;
    set_mode(1'b0, 1'b0, 1'b0);
    pulse_load(16'h0033);
    @(negedge clk);
    cs = 1'b0;
    miso_acc = 16'h0000;
    leader_bits(16'h00F0, 0, 5, 8);
    end_frame();
    check("abort err_cnt", n_err - e0, 1);
    check("abort valid_cnt", n_valid - v0, 0);
    check("abort rx_data", rx_data, model_rx);
    check("abort busy", busy, 1'b0);
    run_frame(1'b0, 1'b0, 1'b0, 16'h0096, 16'h0069, "after_abort", 1'b0);

    // Reset pulsed after bit 10 of a 16-bit frame.
    v0 = n_valid; e0 = n_err;
    set_mode(1'b0, 1'b0, 1'b1);
    pulse_load(16'hCAFE);
    @(negedge clk);
    cs = 1'b0;
    miso_acc = 16'h0000;
    leader_bits(16'hA55A, 0, 10, 16);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst rx_data", rx_data, 16'h0000);
    check("midrst out", out, 1'b0);
    check("midrst busy", busy, 1'b0);
    rst = 1'b0;
    model_rx = 16'h0000;
    repeat (10) @(negedge clk);
    check("midrst no_restart", busy, 1'b0);
    cs = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst valid_cnt", n_valid - v0, 0);
    check("midrst err_cnt", n_err - e0, 0);
    run_frame(1'b0, 1'b0, 1'b1, 16'h0F0F, 16'h1357, "post_rst", 1'b0);

    run_frame(1'b0, 1'b1, 1'b0, 16'h0081, 16'h007E, "mode1", 1'b0);
    run_frame(1'b1, 1'b0, 1'b0, 16'h0081, 16'h007E, "mode2", 1'b0);

    // Random frames; mode pins are scrambled mid-frame and must be ignored.
    for (int k = 0; k < 8; k++) begin
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                16'($urandom), 16'($urandom), $sformatf("rand%0d", k), 1'b1);
    end

    check("never valid_and_err", n_both, 0);
    check("out_zero_when_idle", n_out_idle, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
